// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation codes, FSM states and the
// helper that separates single-cycle ops from iterative multiply/divide.
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_OPW   = 5;

    typedef enum logic [ALU_OPW-1:0] {
        ALU_AND    = 5'd0,
        ALU_OR     = 5'd1,
        ALU_XOR    = 5'd2,
        ALU_ADD    = 5'd3,
        ALU_SUB    = 5'd4,
        ALU_SLL    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_SLTU   = 5'd8,
        ALU_SLT    = 5'd9,
        ALU_MUL    = 5'd10,
        ALU_MULH   = 5'd11,
        ALU_MULHSU = 5'd12,
        ALU_MULHU  = 5'd13,
        ALU_DIV    = 5'd14,
        ALU_DIVU   = 5'd15,
        ALU_REM    = 5'd16,
        ALU_REMU   = 5'd17
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    function automatic logic is_iterative(input alu_op_t op);
        return (op >= ALU_MUL) && (op <= ALU_REMU);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 iterative multiply/divide on operand magnitudes, sharing one
// 2*WIDTH accumulator; sign fix-up is folded into the final step.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step, prod;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    alu_op_t            op_q, op_d;
    logic               neg_q, neg_d, rneg_q, rneg_d;

    logic               is_div, a_signed, b_signed, neg_a, neg_b, div_q, q_bit;
    logic [WIDTH-1:0]   mag_a, mag_b, quo, rem;
    logic [WIDTH:0]     mul_sum, div_top, div_diff;

    always_comb begin
        is_div   = op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
        a_signed = op inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
        b_signed = op inside {ALU_MULH, ALU_DIV, ALU_REM};
        neg_a    = a_signed & a[WIDTH-1];
        neg_b    = b_signed & b[WIDTH-1];
        mag_a    = neg_a ? -a : a;
        mag_b    = neg_b ? -b : b;
    end

    // Multiply: hi += multiplicand when lo[0], then shift right.
    // Divide: shift left, subtract divisor from the partial remainder if it fits.
    always_comb begin
        div_q    = op_q inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_top  = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff = div_top - {1'b0, opnd_q};
        q_bit    = (div_top >= {1'b0, opnd_q});
        if (div_q) begin
            acc_step = {(q_bit ? div_diff[WIDTH-1:0] : div_top[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], q_bit};
        end else begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod = neg_q ? -acc_step : acc_step;
        quo  = acc_step[WIDTH-1:0];
        rem  = acc_step[2*WIDTH-1:WIDTH];
        case (op_q)
            ALU_MUL:                        result = prod[WIDTH-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: result = prod[2*WIDTH-1:WIDTH];
            ALU_DIV, ALU_DIVU:              result = neg_q ? -quo : quo;
            ALU_REM, ALU_REMU:              result = rneg_q ? -rem : rem;
            default:                        result = '0;
        endcase
    end

    // A zero divisor never negates the quotient so it stays all ones;
    // the remainder always takes the dividend's sign, which returns a.
    always_comb begin
        acc_d  = acc_q;
        opnd_d = opnd_q;
        cnt_d  = cnt_q;
        op_d   = op_q;
        neg_d  = neg_q;
        rneg_d = rneg_q;
        if (start) begin
            op_d   = op;
            cnt_d  = CW'(WIDTH);
            acc_d  = {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
            opnd_d = is_div ? mag_b : mag_a;
            neg_d  = (neg_a ^ neg_b) & (!is_div || (b != '0));
            rneg_d = neg_a;
        end else if (cnt_q != '0) begin
            acc_d = acc_step;
            cnt_d = cnt_q - CW'(1);
        end
    end

    assign done = (cnt_q == CW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
            op_q   <= ALU_AND;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            neg_q  <= neg_d;
            rneg_q <= rneg_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked execute-stage ALU: single-cycle ops complete in one cycle,
// RV32M multiply/divide run through muldiv_iter; result and flag are registered.
module seq_alu
    import alu_pkg::*;
#(
    parameter  int WIDTH = ALU_WIDTH,
    parameter  int OPW   = ALU_OPW,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero_flag,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d, single_res, md_result;
    logic             zero_q, zero_d, md_start, md_done;
    alu_op_t          op_e;
    logic [SHW-1:0]   shamt;

    assign op_e  = alu_op_t'(alu_op);
    assign shamt = b[SHW-1:0];

    always_comb begin
        case (op_e)
            ALU_AND:  single_res = a & b;
            ALU_OR:   single_res = a | b;
            ALU_XOR:  single_res = a ^ b;
            ALU_ADD:  single_res = a + b;
            ALU_SUB:  single_res = a - b;
            ALU_SLL:  single_res = a << shamt;
            ALU_SRL:  single_res = a >> shamt;
            ALU_SRA:  single_res = $unsigned($signed(a) >>> shamt);
            ALU_SLTU: single_res = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default:  single_res = '0;
        endcase
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start),
        .op     (op_e),
        .a      (a),
        .b      (b),
        .done   (md_done),
        .result (md_result)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        md_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (is_iterative(op_e)) begin
                        md_start = 1'b1;
                        state_d  = BUSY;
                    end else begin
                        result_d = single_res;
                        zero_d   = (single_res == '0);
                        state_d  = DONE;
                    end
                end
            end
            BUSY: begin
                if (md_done) begin
                    result_d = md_result;
                    zero_d   = (md_result == '0);
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q == BUSY);
    assign alu_result = result_q;
    assign zero_flag  = zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed and random checks of seq_alu against a 64-bit arithmetic reference model.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  alu_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_result;
    logic        zero_flag;
    logic        busy;

    int tests = 0;
    int fails = 0;

    seq_alu #(.WIDTH(32), .OPW(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .alu_op     (alu_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_result (alu_result),
        .zero_flag  (zero_flag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
        longint          sx, sy, p;
        longint unsigned ux, uy, up;
        logic [31:0]     r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        r  = 32'd0;
        case (op)
            5'd0:  r = x & y;
            5'd1:  r = x | y;
            5'd2:  r = x ^ y;
            5'd3:  r = x + y;
            5'd4:  r = x - y;
            5'd5:  r = x << y[4:0];
            5'd6:  r = x >> y[4:0];
            5'd7:  begin p = sx >>> y[4:0]; r = p[31:0]; end
            5'd8:  r = (ux < uy) ? 32'd1 : 32'd0;
            5'd9:  r = (sx < sy) ? 32'd1 : 32'd0;
            5'd10: begin up = ux * uy; r = up[31:0]; end
            5'd11: begin p = sx * sy; r = p[63:32]; end
            5'd12: begin p = sx * longint'(uy); r = p[63:32]; end
            5'd13: begin up = ux * uy; r = up[63:32]; end
            5'd14: begin
                if (y == 32'd0) r = 32'hFFFF_FFFF;
                else begin p = sx / sy; r = p[31:0]; end
            end
            5'd15: begin
                if (y == 32'd0) r = 32'hFFFF_FFFF;
                else begin up = ux / uy; r = up[31:0]; end
            end
            5'd16: begin
                if (y == 32'd0) r = x;
                else begin p = sx % sy; r = p[31:0]; end
            end
            5'd17: begin
                if (y == 32'd0) r = x;
                else begin up = ux % uy; r = up[31:0]; end
            end
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, measure latency and busy/in_ready behaviour, then
    // optionally hold the result under backpressure for `hold` cycles.
    task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] av,
                         input logic [31:0] bv, input int hold);
        int          lat, bc, irc, w;
        logic [31:0] exp, held;
        logic        iter;
        exp  = ref_alu(op, av, bv);
        iter = (op >= 5'd10) && (op <= 5'd17);
        w = 0;
        while (!in_ready && w < 100) begin step(); w++; end
        chk({tag, "/ready_in"}, {31'd0, in_ready}, 32'd1);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        alu_op    = op;
        a         = av;
        b         = bv;
        step();
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        lat = 1; bc = 0; irc = 0;
        while (!out_valid && lat < 100) begin
            if (busy) bc++;
            if (in_ready) irc++;
            step();
            lat++;
        end
        chk({tag, "/latency"}, 32'(lat), iter ? 32'd33 : 32'd1);
        chk({tag, "/result"}, alu_result, exp);
        chk({tag, "/zero"}, {31'd0, zero_flag}, {31'd0, (exp == 32'd0)});
        chk({tag, "/busy_cycles"}, 32'(bc), iter ? 32'd32 : 32'd0);
        chk({tag, "/ready_while_busy"}, 32'(irc), 32'd0);
        $display("[TB] %s op=%0d a=%h b=%h -> %h (latency %0d)", tag, op, av, bv, alu_result, lat);
        if (hold > 0) begin
            held     = alu_result;
            in_valid = 1'b1;
            alu_op   = 5'd3;
            a        = 32'd1;
            b        = 32'd1;
            for (int i = 0; i < hold; i++) begin
                step();
                chk({tag, "/hold_valid"}, {31'd0, out_valid}, 32'd1);
                chk({tag, "/hold_result"}, alu_result, held);
                chk({tag, "/hold_zero"}, {31'd0, zero_flag}, {31'd0, (held == 32'd0)});
                chk({tag, "/hold_ready"}, {31'd0, in_ready}, 32'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            step();
            chk({tag, "/release_ready"}, {31'd0, in_ready}, 32'd1);
            chk({tag, "/release_valid"}, {31'd0, out_valid}, 32'd0);
        end else begin
            step();
        end
    endtask

    initial begin
        logic [4:0]  rop;
        logic [31:0] ra, rb;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 32'd0;
        b         = 32'd0;
        alu_op    = 5'd0;
        repeat (3) step();
        reset = 1'b0;
        chk("reset/out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset/result", alu_result, 32'd0);
        chk("reset/zero", {31'd0, zero_flag}, 32'd1);
        chk("reset/busy", {31'd0, busy}, 32'd0);
        chk("reset/in_ready", {31'd0, in_ready}, 32'd1);

        do_op("add_wrap", 5'd3,  32'hFFFF_FFFF, 32'd1, 0);
        do_op("slt",      5'd9,  32'hFFFF_FFFF, 32'd1, 0);
        do_op("sltu",     5'd8,  32'hFFFF_FFFF, 32'd1, 0);
        do_op("sra",      5'd7,  32'h8000_0000, 32'h0000_0024, 0);
        do_op("sll33",    5'd5,  32'h0000_0003, 32'd33, 0);
        do_op("mulh",     5'd11, 32'h8000_0000, 32'h8000_0000, 0);
        do_op("mulhu",    5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op("div_ovf",  5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op("rem_ovf",  5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op("divu_z",   5'd15, 32'd7, 32'd0, 0);
        do_op("remu_z",   5'd17, 32'd7, 32'd0, 0);
        do_op("div_neg",  5'd14, 32'hFFFF_FFF9, 32'd2, 0);
        do_op("rem_neg",  5'd16, 32'hFFFF_FFF9, 32'd2, 0);
        do_op("illegal",  5'd20, 32'h1234_5678, 32'd9, 0);
        do_op("bp_sub",   5'd4,  32'd10, 32'd3, 5);
        do_op("bp_mul",   5'd10, 32'hFFFF_FFFD, 32'd7, 5);

        // Reset in the middle of an unsigned divide.
        in_valid = 1'b1;
        alu_op   = 5'd15;
        a        = 32'd100;
        b        = 32'd7;
        step();
        in_valid = 1'b0;
        repeat (9) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst/out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst/result", alu_result, 32'd0);
        chk("midrst/zero", {31'd0, zero_flag}, 32'd1);
        chk("midrst/busy", {31'd0, busy}, 32'd0);
        chk("midrst/in_ready", {31'd0, in_ready}, 32'd1);
        $display("[TB] reset asserted mid-DIVU, outputs returned to reset values");
        do_op("after_rst", 5'd3, 32'd2, 32'd3, 0);

        for (int i = 0; i < 40; i++) begin
            rop = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(18, 31)) : 5'($urandom_range(0, 17));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 9) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            do_op("rnd", rop, ra, rb, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor to the single-cycle combinational ALU.
- Keeps the existing ten-operation encoding and adds the RV32M multiply/divide/remainder set, executed iteratively.
- Result and zero flag are registered.
- Sits in the execute stage; the control FSM stalls on in_ready/out_valid for multi-cycle ops.

Parameters:
- WIDTH, 32, operand/result width in bits (power of two, >= 8).
- OPW, 5, width of the operation code.
- SHW, $clog2(WIDTH), number of low bits of b used as the shift amount (derived, not overridable).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  block can accept a request this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- alu_op  in  OPW  operation code
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes the result this cycle
- alu_result  out  WIDTH  registered result
- zero_flag  out  1  high when alu_result == 0, registered with alu_result
- busy  out  1  iterative operation in progress

Behaviour:
- Clock/reset: one clock, clk. reset is synchronous and active-high. Reset dominates every other input in the same cycle.
- Reset values: state=IDLE, in_ready=1 after reset releases, out_valid=0, busy=0, alu_result=0, zero_flag=1.
- Op codes:
  - 0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB
  - 5 SLL, 6 SRL, 7 SRA
  - 8 SLTU, 9 SLT
  - 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU
  - 14 DIV, 15 DIVU, 16 REM, 17 REMU
  - Any other code: result 0, single-cycle.
- Shifts use b[SHW-1:0] only. SRA is arithmetic on signed a.
- SLT/SLTU produce a zero-extended 0/1.
- ADD/SUB/MUL wrap modulo 2^WIDTH.
- FSM states IDLE, BUSY, DONE:
  - in_ready = (state==IDLE). A request is accepted on in_valid && in_ready, and operands are captured that cycle.
  - IDLE, single-cycle op accepted in cycle N: go to DONE. out_valid=1 in cycle N+1.
  - IDLE, op 10..17 accepted: go to BUSY, counter=WIDTH, busy=1.
  - BUSY: one radix-2 step per cycle, counter decrements. When the counter reaches 0, apply sign fix-up, register the result and go to DONE. out_valid rises at N+WIDTH+1.
  - DONE: alu_result/zero_flag held stable while out_ready=0. On out_ready=1, go to IDLE. There is no same-cycle re-accept; the next request is accepted no earlier than the following cycle.
- Signed mul/div operate on magnitudes, with result negation applied during the final BUSY cycle. MULH/MULHSU/MULHU return the upper WIDTH bits of the 2*WIDTH product.
- Divide by zero (no exception):
  - DIV/DIVU quotient = all ones.
  - REM/REMU = a.
  - Still takes the full WIDTH+1 cycles.
- Signed overflow, a = most-negative and b = -1: DIV = a, REM = 0.
- Reset mid-operation (BUSY or DONE): abort immediately, discard the partial result, return to reset values next cycle.
- in_valid while not in_ready: ignored. The requester must hold the request.
- out_valid never drops without out_ready or reset.

Decomposition:
- alu_pkg:
  - typedef enum logic [OPW-1:0] alu_op_t with the 18 codes
  - typedef enum state_t {IDLE, BUSY, DONE}
  - helper function is_iterative(op)
  - default WIDTH constant
- Sub-module muldiv_iter (one per instance), owning the iterative datapath:
  - shift-add multiplier and restoring divider sharing one 2*WIDTH accumulator
  - start/done pulses and the sign fix-up
- seq_alu holds the FSM, the single-cycle op mux and the output registers.

Test Plan:
- ADD 0xFFFFFFFF + 1 accepted at cycle N -> out_valid at N+1, alu_result=0, zero_flag=1. SLT a=0xFFFFFFFF, b=1 -> 1. SLTU with the same operands -> 0.
- SRA a=0x80000000, b=0x00000024 (shift 4) -> 0xF8000000. SLL by b=33 -> shift 1, confirming only b[4:0] is used.
- MULH a=0x80000000, b=0x80000000 -> 0x40000000 at N+33, busy high for 32 cycles, in_ready low throughout. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0. DIVU 7/0 -> 0xFFFFFFFF. REMU 7/0 -> 7. DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result/flag stable, in_ready=0, in_valid requests not taken. Release -> IDLE the next cycle, then accept.
- Assert reset for 1 cycle mid-DIVU (cycle N+10) -> out_valid=0, alu_result=0, zero_flag=1, busy=0 next cycle. A subsequent ADD 2+3 -> 5 at the expected latency.
